// File: rtl/div_32b_seq_if.sv
// Handshake and operand/result bundle between the control unit (master)
// and the sequential divider (slave).
interface div_32b_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, signed_op, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, signed_op, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_32b_seq.sv
// Restoring shift/subtract divider, one quotient bit per clock, for DIV/DIVU.
// Signed operands are divided as magnitudes and the signs are fixed up afterwards.
module div_32b_seq #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    div_32b_seq_if.slave    bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] part_q;       // partial remainder
    logic [WIDTH-1:0] dvd_q;        // dividend magnitude, shifted out as quotient bits shift in
    logic [WIDTH-1:0] dvs_q;        // divisor magnitude
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;

    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH:0]   p_shift;
    logic [WIDTH-1:0] trial;
    logic             q_bit;
    logic             busy, done;

    // Operand magnitudes; the most negative value maps to itself, which is
    // the correct unsigned magnitude.
    assign dvd_neg = bus.signed_op & bus.dividend[WIDTH-1];
    assign dvs_neg = bus.signed_op & bus.divisor[WIDTH-1];
    assign dvd_mag = dvd_neg ? -bus.dividend : bus.dividend;
    assign dvs_mag = dvs_neg ? -bus.divisor  : bus.divisor;

    // Shifted partial remainder is WIDTH+1 bits; when the subtraction succeeds
    // the true difference is below the divisor, so WIDTH bits hold it exactly.
    assign p_shift = {part_q, dvd_q[WIDTH-1]};
    assign q_bit   = (p_shift >= {1'b0, dvs_q});
    assign trial   = p_shift[WIDTH-1:0] - dvs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = (bus.divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            part_q      <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor == '0) begin
                            quotient_q  <= '1;
                            remainder_q <= bus.dividend;
                            dbz_q       <= 1'b1;
                        end else begin
                            dvd_q     <= dvd_mag;
                            dvs_q     <= dvs_mag;
                            part_q    <= '0;
                            cnt_q     <= CW'(WIDTH - 1);
                            neg_quo_q <= dvd_neg ^ dvs_neg;
                            neg_rem_q <= dvd_neg;
                            dbz_q     <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    part_q <= q_bit ? trial : p_shift[WIDTH-1:0];
                    dvd_q  <= {dvd_q[WIDTH-2:0], q_bit};
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                FIX: begin
                    // Truncation toward zero: remainder follows the dividend's sign.
                    quotient_q  <= neg_quo_q ? -dvd_q  : dvd_q;
                    remainder_q <= neg_rem_q ? -part_q : part_q;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_div_32b_seq.sv
// Directed-vector bench for div_32b_seq: an arithmetic reference model feeds a
// scoreboard that checks results, latency and result hold on every cycle.
module tb_div_32b_seq;
    localparam int WIDTH = 32;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_vec;
    int   n_err;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    exp_t res;

    div_32b_seq_if #(.WIDTH(WIDTH)) bus ();

    div_32b_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: plain integer division, truncating toward zero for signed.
    function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, lq, lr;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (!sgn) return {a / b, a % b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        lq = sa / sb;
        lr = sa % sb;
        return {lq[31:0], lr[31:0]};
    endfunction

    // Pins the model to the hand-computed literals, then queues its answer.
    task automatic push_exp(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] lq, input logic [31:0] lr, input bit ldbz);
        exp_t e;
        logic [63:0] m;
        m = model(sgn, a, b);
        check("model_quotient", m[63:32], lq);
        check("model_remainder", m[31:0], lr);
        check("model_dbz", 32'(b == 32'd0), 32'(ldbz));
        e.q   = m[63:32];
        e.r   = m[31:0];
        e.dbz = (b == 32'd0);
        e.due = cyc + 1 + ((b == 32'd0) ? 0 : WIDTH + 1);
        exp_q.push_back(e);
    endtask

    task automatic run_vec(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] lq, input logic [31:0] lr, input bit ldbz);
        @(negedge clk);
        bus.signed_op = sgn;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.start     = 1'b1;
        push_exp(sgn, a, b, lq, lr, ldbz);
        @(negedge clk);
        bus.start     = 1'b0;
        bus.dividend  = $urandom;
        bus.divisor   = $urandom;
        bus.signed_op = 1'($urandom_range(0, 1));
        check("busy_after_start", 32'(bus.busy), 32'd1);
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) @(negedge clk);
        $display("vector %s %h / %h -> q=%h r=%h dbz=%0b", sgn ? "S" : "U", a, b,
                 bus.quotient, bus.remainder, bus.div_by_zero);
    endtask

    // Scoreboard: results and latency at done, held values while idle.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            res.q   = '0;
            res.r   = '0;
            res.dbz = 1'b0;
        end else begin
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    check("done_unexpected", 32'(bus.done), 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    check("done_latency", 32'(cyc), 32'(cur.due));
                    check("quotient", bus.quotient, cur.q);
                    check("remainder", bus.remainder, cur.r);
                    check("div_by_zero", 32'(bus.div_by_zero), 32'(cur.dbz));
                    res = cur;
                end
            end else begin
                if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
                    check("done_timeout", 32'(cyc), 32'(exp_q[0].due));
                    void'(exp_q.pop_front());
                end
                if (!bus.busy) begin
                    check("hold_quotient", bus.quotient, res.q);
                    check("hold_remainder", bus.remainder, res.r);
                    check("hold_dbz", 32'(bus.div_by_zero), 32'(res.dbz));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc           = 0;
        n_vec         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_quotient", bus.quotient, 32'd0);
        check("reset_remainder", bus.remainder, 32'd0);
        check("reset_dbz", 32'(bus.div_by_zero), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_vec(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        repeat (10) @(negedge clk);
        run_vec(1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_vec(1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,        1'b0);
        run_vec(1'b0, 32'd5,         32'd0,        32'hFFFF_FFFF, 32'd5,        1'b1);
        repeat (3) @(negedge clk);
        run_vec(1'b1, 32'd5,         32'd0,        32'hFFFF_FFFF, 32'd5,        1'b1);
        run_vec(1'b0, 32'd9,         32'd3,        32'd3,         32'd0,        1'b0);
        run_vec(1'b1, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
        run_vec(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,       1'b0);
        run_vec(1'b0, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 32'd0,        1'b0);
        run_vec(1'b0, 32'd0,         32'd5,        32'd0,         32'd0,        1'b0);
        run_vec(1'b0, 32'd3,         32'd10,       32'd0,         32'd3,        1'b0);
        run_vec(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,        32'd1,        1'b0);
        run_vec(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 1'b0);

        // Starts during CALC and during the DONE cycle must be ignored.
        @(negedge clk);
        bus.signed_op = 1'b0;
        bus.dividend  = 32'd100;
        bus.divisor   = 32'd7;
        bus.start     = 1'b1;
        push_exp(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        bus.dividend = 32'd50;
        bus.divisor  = 32'd5;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 40 && !bus.done; i++) @(negedge clk);
        check("ignore_done_seen", 32'(bus.done), 32'd1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("ignore_busy_after_done", 32'(bus.busy), 32'd0);
        repeat (40) @(negedge clk);
        $display("ignored-start run -> q=%h r=%h", bus.quotient, bus.remainder);

        // Asynchronous reset in the middle of CALC aborts without a done pulse.
        @(negedge clk);
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_quotient", bus.quotient, 32'd0);
        check("abort_remainder", bus.remainder, 32'd0);
        check("abort_dbz", 32'(bus.div_by_zero), 32'd0);
        $display("reset mid-CALC -> busy=%0b q=%h r=%h", bus.busy, bus.quotient, bus.remainder);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        run_vec(1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 1'b0);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
